// File: rtl/seg7_pkg.sv
// Shared constants and state type for the 7-segment scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment patterns, active-low: bit7 = dp, bits6:0 = g..a.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  // BLANK = dead time at the start of a slot, DRIVE = digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer: walks each digit slot through BLANK then DRIVE, advances the digit index.
// Latency: state/cnt/idx update every enabled cycle; frame_done is registered.
// Backpressure: ena low freezes state, cnt and idx; frame_done stays low.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   ena            advance enable
//   state/cnt/idx  current slot phase, cycle within slot, digit index
//   frame_done     one-cycle pulse after the last digit's slot wraps to digit 0
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  output scan_state_t                    state,
  output logic [$clog2(SLOT_CYCLES)-1:0] cnt,
  output logic [$clog2(NUM_DIGITS)-1:0]  idx,
  output logic                           frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  scan_state_t     state_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [IW-1:0]   idx_nxt;
  logic            wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_done <= wrap;
    end
  end

  // cnt runs continuously across the slot; BLANK/DRIVE only marks which part we are in.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (ena) begin
      case (state)
        BLANK: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == DEAD_LAST) begin
            state_nxt = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = BLANK;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes per-digit 7-segment patterns onto one segment bus plus active-low anodes.
// Latency: SEG/AN registered, one cycle behind the slot state; DISP snapshotted once per frame.
// Backpressure: ena low holds the scan position and blanks the display from the next cycle.
//
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   ena         scan enable
//   DISP        8 bits per digit, digit 0 in the low byte (active-low segments)
//   SEG         shared segment bus, same encoding as DISP
//   AN          anode enables, active-low, at most one low
//   frame_done  one-cycle pulse at the end of each frame
// Optional: define SEG7_LZ_BLANK_EN for leading-zero blanking of digits above digit 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [8*NUM_DIGITS-1:0] DISP,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  scan_state_t                      state;
  logic [CW-1:0]                    cnt;
  logic [IW-1:0]                    idx;
  logic [NUM_DIGITS-1:0][7:0]       disp_d;
  logic [NUM_DIGITS-1:0][7:0]       snap;
  logic                             capture;
  logic [NUM_DIGITS-1:0]            supp;
  logic [7:0]                       seg_nxt;
  logic [NUM_DIGITS-1:0]            an_nxt;

  seg7_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_CYCLES(SLOT_CYCLES),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .state     (state),
    .cnt       (cnt),
    .idx       (idx),
    .frame_done(frame_done)
  );

  assign disp_d = DISP;

  // First cycle of digit 0's slot: the whole display is latched together so no digit tears.
  assign capture = ena && (state == BLANK) && (idx == '0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= {NUM_DIGITS{SEG_BLANK}};
    end else if (capture) begin
      snap <= disp_d;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] supp_nxt;
  logic                  lz_run;

  // Scan from the most significant digit down; suppression stops at the first non-zero.
  // Digit 0 is never suppressed so a value of zero still shows one '0'.
  always_comb begin
    supp_nxt = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (disp_d[k] == SEG_ZERO);
      supp_nxt[k] = lz_run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      supp <= '0;
    end else if (capture) begin
      supp <= supp_nxt;
    end
  end
`else
  assign supp = '0;
`endif

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = '1;
    if (ena && (state == DRIVE) && !supp[idx]) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = snap[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
    end else begin
      SEG <= seg_nxt;
      AN  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: vector table, hand sequences and random stimulus
// against a position-in-frame reference model.
// Optional: SEG7_LZ_BLANK_EN changes the expected suppression of leading zeros.
module tb_seg7_scan_driver;

  localparam int N     = 2;
  localparam int SLOT  = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = N * SLOT;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic [8*N-1:0]   disp;
  logic [7:0]       seg;
  logic [N-1:0]     an;
  logic             fd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the frame in enabled cycles, plus captured snapshot.
  int         pos;
  logic [7:0] m_snap [N];
  logic       m_supp [N];
  logic [N-1:0] e_an;
  logic [7:0]   e_seg;
  logic         e_fd;

  typedef struct {
    logic        ena;
    logic [15:0] disp;
    int          cycles;
    logic [1:0]  an;
    logic [7:0]  seg;
    logic        fd;
  } vec_t;

  vec_t vt [7];

  seg7_scan_driver #(
    .NUM_DIGITS (N),
    .SLOT_CYCLES(SLOT),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .DISP      (disp),
    .SEG       (seg),
    .AN        (an),
    .frame_done(fd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int k = 0; k < N; k++) begin
      m_snap[k] = 8'hFF;
      m_supp[k] = 1'b0;
    end
  endtask

  // Predict the outputs after the coming edge, advance the model, then compare.
  task automatic tick();
    int   slot;
    int   off;
    logic run;
    e_an  = '1;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
    if (rst && ena) begin
      if (pos == 0) begin
        run = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
          m_snap[k] = disp[8*k +: 8];
`ifdef SEG7_LZ_BLANK_EN
          run = run && (k > 0) && (disp[8*k +: 8] == 8'hC0);
`else
          run = 1'b0;
`endif
          m_supp[k] = run;
        end
      end
      slot = pos / SLOT;
      off  = pos % SLOT;
      if (off >= DEAD && !m_supp[slot]) begin
        e_an[slot] = 1'b0;
        e_seg      = m_snap[slot];
      end
      e_fd = (pos == FRAME - 1);
      pos  = (pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    check("model", 32'({an, seg, fd}), 32'({e_an, e_seg, e_fd}));
  endtask

  task automatic wait_pos(input int p);
    int g = 0;
    while (pos != p && g < 64) begin
      tick();
      g++;
    end
    check("wait_pos", 32'(pos), 32'(p));
  endtask

  initial begin
    int   lit;
    int   lit0;
    int   lit1;
    int   g;
    logic low_done;
    logic seen;

    // Reset release with DISP = {F9, A4}: per-cycle expected outputs.
    vt[0] = '{1'b1, 16'hF9A4, 2, 2'b11, 8'hFF, 1'b0};
    vt[1] = '{1'b1, 16'hF9A4, 6, 2'b10, 8'hA4, 1'b0};
    vt[2] = '{1'b1, 16'hF9A4, 2, 2'b11, 8'hFF, 1'b0};
    vt[3] = '{1'b1, 16'hF9A4, 5, 2'b01, 8'hF9, 1'b0};
    vt[4] = '{1'b1, 16'hF9A4, 1, 2'b01, 8'hF9, 1'b1};
    vt[5] = '{1'b1, 16'hF9A4, 2, 2'b11, 8'hFF, 1'b0};
    vt[6] = '{1'b1, 16'hF9A4, 6, 2'b10, 8'hA4, 1'b0};

    rst  = 1'b0;
    ena  = 1'b1;
    disp = 16'hF9A4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({an, seg, fd}), 32'({2'b11, 8'hFF, 1'b0}));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      ena  = vt[i].ena;
      disp = vt[i].disp;
      for (int c = 0; c < vt[i].cycles; c++) begin
        tick();
        check("vector", 32'({an, seg, fd}), 32'({vt[i].an, vt[i].seg, vt[i].fd}));
      end
    end

    // Random DISP and occasional ena drops: anode exclusivity and blank bus.
    for (int i = 0; i < 1000; i++) begin
      disp = 16'($urandom);
      ena  = ($urandom_range(0, 9) != 0);
      tick();
      check("an_onehot", 32'(an == 2'b11 || an == 2'b10 || an == 2'b01), 32'(1));
      if (an == 2'b11) check("seg_blank", 32'(seg), 32'(8'hFF));
    end

    // Snapshot: a DISP0 change during digit-1 drive shows only in the next frame.
    ena  = 1'b1;
    disp = 16'hF9A4;
    wait_pos(0);
    wait_pos(11);
    disp[7:0] = 8'h99;
    seen = 1'b0;
    g    = 0;
    while (!seen && g < 40) begin
      tick();
      if (fd) seen = 1'b1;
      g++;
    end
    check("fd_seen", 32'(seen), 32'(1));
    g = 0;
    while (an != 2'b10 && g < 40) begin
      tick();
      g++;
    end
    check("snap_new", 32'({an, seg}), 32'({2'b10, 8'h99}));

    // ena low for 5 cycles mid digit-0 drive: lit cycles for the slot stay at 6.
    wait_pos(0);
    lit      = 0;
    g        = 0;
    low_done = 1'b0;
    while (pos != 9 && g < 40) begin
      if (pos == 4 && !low_done) begin
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          if (an == 2'b10) lit++;
          if (i == 0) check("ena_low_blank", 32'({an, seg}), 32'({2'b11, 8'hFF}));
        end
        ena      = 1'b1;
        low_done = 1'b1;
        g += 5;
      end else begin
        tick();
        if (an == 2'b10) lit++;
        g++;
      end
    end
    check("lit_cycles", 32'(lit), 32'(6));

    // Asynchronous reset mid-drive: outputs clear with no clock edge.
    wait_pos(5);
    check("pre_reset_lit", 32'(an), 32'(2'b10));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 32'({an, seg, fd}), 32'({2'b11, 8'hFF, 1'b0}));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("restart_blank", 32'(an), 32'(2'b11));
    tick();
    check("restart_digit0", 32'(an), 32'(2'b10));

    // Leading-zero blanking: digit 1 = '0', digit 0 = '1'.
    disp = 16'hC0F9;
    wait_pos(0);
    lit0 = 0;
    lit1 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!an[0]) lit0++;
      if (!an[1]) lit1++;
    end
    check("lz_digit0", 32'(lit0), 32'(12));
`ifdef SEG7_LZ_BLANK_EN
    check("lz_digit1_zero", 32'(lit1), 32'(0));
`else
    check("lz_digit1_zero", 32'(lit1), 32'(12));
`endif

    disp = 16'hF9F9;
    lit1 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!an[1]) lit1++;
    end
    check("lz_digit1_nonzero", 32'(lit1), 32'(12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream stage of the sequence detector. Consumes its per-digit 7-segment patterns (DISP0/DISP1) and time-multiplexes them onto one shared segment bus plus per-digit anode enables for the board display.
- Inputs are snapshotted once per frame so a digit never tears.
- Each digit slot starts with a dead-time blank to prevent ghosting.

Parameters:
- NUM_DIGITS, 2: number of multiplexed digits (>=2).
- SLOT_CYCLES, 100000: clock cycles per digit slot, including dead time (>DEAD_CYCLES).
- DEAD_CYCLES, 1000: blanking cycles at the start of each slot (>=1).

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-low.
- ena  in  1: scan enable. Low freezes scanning and blanks the display.
- DISP  in  8*NUM_DIGITS: segment patterns. DISP[8k+7:8k] is digit k, digit 0 = ones. Bit7 = dp, bits6:0 = g..a, active-low (1 = segment off).
- SEG  out  8: shared segment bus, same encoding as DISP.
- AN  out  NUM_DIGITS: anode enables, active-low, at most one bit low at any time.
- frame_done  out  1: one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Reset (rst=0, takes effect immediately with no clock edge):
  - SEG=8'hFF, AN=all ones, frame_done=0.
  - Snapshot = all 8'hFF, digit index idx=0, slot counter cnt=0, state BLANK.
- State machine, cnt width $clog2(SLOT_CYCLES):
  - BLANK: cnt counts 0..DEAD_CYCLES-1, then go to DRIVE.
  - DRIVE: cnt counts DEAD_CYCLES..SLOT_CYCLES-1. At SLOT_CYCLES-1: cnt<=0, idx<=idx+1, state<=BLANK.
  - idx wraps NUM_DIGITS-1 -> 0.
- frame_done:
  - Registered. Asserted for exactly one cycle, on the cycle after the DRIVE->BLANK transition where idx wraps to 0.
- Snapshot:
  - All of DISP is captured on an enabled cycle with state=BLANK, idx=0, cnt=0.
  - This includes the first enabled cycle after reset release.
  - DISP changes between captures have no visible effect.
- Outputs (registered, one-cycle latency from state):
  - BLANK: AN=all ones, SEG=8'hFF.
  - DRIVE: AN[idx]=0 and other bits 1; SEG=snapshot[idx].
- ena=0:
  - state, cnt, idx and snapshot hold.
  - Next cycle AN=all ones, SEG=8'hFF; frame_done stays 0.
  - When ena returns to 1, the slot resumes at the held cnt, with outputs valid one cycle later.
- Timing:
  - Frame period = NUM_DIGITS*SLOT_CYCLES enabled cycles.
  - Each digit is lit for SLOT_CYCLES-DEAD_CYCLES cycles per frame.
- Simultaneous events:
  - ena falling on the wrap cycle: the transition is not taken and cnt holds.
  - Reset overrides everything.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Digit k>0 is suppressed when its snapshot equals SEG_ZERO (8'hC0) and every digit above k is also suppressed.
  - Suppressed means AN stays all ones for that whole slot. Slot timing is unchanged.
  - Digit 0 is never suppressed.
  - Mask computed from the snapshot, at capture time.
- Undefined: all digits are always driven.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=8'hFF and SEG_ZERO=8'hC0.
  - State enum scan_state_t {BLANK, DRIVE}.
- One natural sub-module, seg7_slot_timer: owns cnt, idx, state and the wrap/frame pulse, gated by ena.
- The top level holds the snapshot, the optional LZ mask and the output registers.

Test Plan:
Bench uses SLOT_CYCLES=8, DEAD_CYCLES=2, NUM_DIGITS=2.
1. Reset release, DISP={8'hF9,8'hA4}: after release, a 2-cycle blank; then AN=2'b10 with SEG=8'hA4 for 6 cycles; 2-cycle blank; AN=2'b01 with SEG=8'hF9 for 6 cycles; frame_done pulses once every 16 cycles.
2. Anode exclusivity: over 1000 cycles of random DISP, AN is never anything other than 2'b11, 2'b10 or 2'b01, and SEG=8'hFF whenever AN=2'b11.
3. Snapshot: DISP0 changes 8'hA4->8'h99 during digit-1 DRIVE -> SEG shows 8'hA4 until frame_done, then 8'h99 in the next digit-0 slot.
4. ena low for 5 cycles mid digit-0 DRIVE -> AN=2'b11 one cycle later. After ena rises, AN=2'b10 again for the remaining lit cycles, so total lit cycles for that slot = 6.
5. rst asserted mid-DRIVE with no clock edge -> AN=2'b11, SEG=8'hFF, frame_done=0 immediately. Sequence restarts from digit 0 after release.
6. SEG7_LZ_BLANK_EN defined, DISP1=8'hC0, DISP0=8'hF9 -> AN[1] never low and digit 0 is shown normally. With DISP1=8'hF9, AN[1] is low for 6 cycles per frame.
